// File: rtl/div_pkg.sv
// Shared types for the restoring divider slice.
// State encoding and the default operand width.
package div_pkg;

  localparam int NBIT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_sequencer_if.sv
// Request/result bundle between a divider client and div_sequencer.
// The master drives operands and start; the slave returns status and results.
interface div_sequencer_if
  import div_pkg::*;
#(
   parameter int NBIT = NBIT_DEF
) ();

   logic            start;
   logic [NBIT-1:0] dividend;
   logic [NBIT-1:0] divisor;
   logic            busy;
   logic            done;
   logic [NBIT-1:0] quotient;
   logic [NBIT-1:0] remainder;
   logic            div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient,
      input  remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient,
      output remainder, div_by_zero
   );

endinterface

// File: rtl/div_shift_pair.sv
// Combined {A,Q} register of the restoring divider.
// Shifts left with a serial quotient bit; A may take the trial difference.
module div_shift_pair #(
   parameter int NBIT = 16
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            load,
   input  logic [NBIT-1:0] q_init,
   input  logic            shift,
   input  logic            sin,
   input  logic            a_we,
   input  logic [NBIT-1:0] a_in,
   output logic [NBIT-1:0] a,
   output logic [NBIT-1:0] q
);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         a <= '0;
         q <= '0;
      end else if (load) begin
         a <= '0;
         q <= q_init;
      end else if (shift) begin
         a <= a_we ? a_in : {a[NBIT-2:0], q[NBIT-1]};
         q <= {q[NBIT-2:0], sin};
      end
   end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock.
// Zero divisors skip the iteration and report div_by_zero.
module div_sequencer
  import div_pkg::*;
#(
   parameter int NBIT = NBIT_DEF
) (
   input  logic      clk,
   input  logic      clr,
   div_sequencer_if.slave bus
);

   localparam int CW = $clog2(NBIT);

   state_t          state;
   state_t          state_nx;
   logic [CW-1:0]   cnt;
   logic [NBIT-1:0] m;
   logic [NBIT-1:0] a;
   logic [NBIT-1:0] q;
   logic [NBIT:0]   t;
   logic [NBIT-1:0] a_sh;
   logic            ok;
   logic            accept;
   logic            zdiv;
   logic            last;

   assign zdiv   = (bus.divisor == '0);
   assign accept = (state == IDLE) && bus.start;
   assign last   = (state == RUN) && (cnt == '0);

   // Trial subtract at NBIT+1 bits so A's shifted-out MSB is kept.
   assign a_sh = {a[NBIT-2:0], q[NBIT-1]};
   assign t    = {a, q[NBIT-1]} - {1'b0, m};
   assign ok   = ~t[NBIT];

   div_shift_pair #(
      .NBIT (NBIT)
   ) u_pair (
      .clk    (clk),
      .clr    (clr),
      .load   (accept && !zdiv),
      .q_init (bus.dividend),
      .shift  (state == RUN),
      .sin    (ok),
      .a_we   (ok),
      .a_in   (t[NBIT-1:0]),
      .a      (a),
      .q      (q)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (bus.start) state_nx = zdiv ? DONE : RUN;
         RUN:     if (cnt == '0) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state == RUN);
      bus.done = (state == DONE);
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt <= '0;
         m   <= '0;
      end else if (accept && !zdiv) begin
         cnt <= CW'(NBIT - 1);
         m   <= bus.divisor;
      end else if (state == RUN && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         bus.quotient    <= '0;
         bus.remainder   <= '0;
         bus.div_by_zero <= 1'b0;
      end else if (accept && zdiv) begin
         bus.quotient    <= '1;
         bus.remainder   <= bus.dividend;
         bus.div_by_zero <= 1'b1;
      end else if (last) begin
         bus.quotient    <= {q[NBIT-2:0], ok};
         bus.remainder   <= ok ? t[NBIT-1:0] : a_sh;
         bus.div_by_zero <= 1'b0;
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer at NBIT=16.
// Each scenario task checks its own hand-computed expectations.
module tb_div_sequencer;

   logic clk;
   logic clr;
   int   total;
   int   passed;

   div_sequencer_if #(.NBIT(16)) bus ();

   div_sequencer #(
      .NBIT (16)
   ) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [15:0] dd, input logic [15:0] dv);
      bus.start    = 1'b1;
      bus.dividend = dd;
      bus.divisor  = dv;
      step();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output int bcnt, output bit tmo);
      bcnt = 0;
      tmo  = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (bus.done) begin
            tmo = 1'b0;
            break;
         end
         if (bus.busy) bcnt++;
         step();
      end
   endtask

   task automatic test_reset();
      clr = 1'b1;
      bus.start = 1'b0;
      bus.dividend = '0;
      bus.divisor = '0;
      #12;
      total++;
      if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000)
         $display("FAIL reset_flags got %b want 000",
                  {bus.busy, bus.done, bus.div_by_zero});
      else passed++;
      total++;
      if ({bus.quotient, bus.remainder} !== 32'h0)
         $display("FAIL reset_results got %h want 0",
                  {bus.quotient, bus.remainder});
      else passed++;
      @(negedge clk);
      clr = 1'b0;
      #1;
   endtask

   task automatic test_basic();
      int bcnt;
      bit tmo;
      launch(16'd100, 16'd7);
      wait_done(bcnt, tmo);
      total++;
      if (tmo || bcnt != 16)
         $display("FAIL basic_latency got %0d tmo %0b want 16", bcnt, tmo);
      else passed++;
      total++;
      if ({bus.quotient, bus.remainder, bus.div_by_zero} !==
          {16'd14, 16'd2, 1'b0})
         $display("FAIL basic_result got %0d r %0d z %b want 14 r 2 z 0",
                  bus.quotient, bus.remainder, bus.div_by_zero);
      else passed++;
      step();
      total++;
      if (bus.done !== 1'b0 || bus.quotient !== 16'd14)
         $display("FAIL basic_pulse got done %b q %0d want 0 14",
                  bus.done, bus.quotient);
      else passed++;
   endtask

   task automatic test_div_zero();
      int bcnt;
      bit tmo;
      launch(16'h1234, 16'h0000);
      wait_done(bcnt, tmo);
      total++;
      if (tmo || bcnt != 0)
         $display("FAIL dz_latency got %0d tmo %0b want 0", bcnt, tmo);
      else passed++;
      total++;
      if ({bus.quotient, bus.remainder, bus.div_by_zero} !==
          {16'hFFFF, 16'h1234, 1'b1})
         $display("FAIL dz_result got %h r %h z %b want ffff r 1234 z 1",
                  bus.quotient, bus.remainder, bus.div_by_zero);
      else passed++;
      step();
      total++;
      if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b1)
         $display("FAIL dz_hold got done %b z %b want 0 1",
                  bus.done, bus.div_by_zero);
      else passed++;
   endtask

   task automatic test_boundary();
      int bcnt;
      bit tmo;
      launch(16'hFFFF, 16'd1);
      wait_done(bcnt, tmo);
      total++;
      if (tmo || {bus.quotient, bus.remainder} !== {16'hFFFF, 16'h0})
         $display("FAIL ones_by_one got %h r %h want ffff r 0",
                  bus.quotient, bus.remainder);
      else passed++;
      step();
      launch(16'd5, 16'd9);
      wait_done(bcnt, tmo);
      total++;
      if (tmo || {bus.quotient, bus.remainder} !== {16'd0, 16'd5})
         $display("FAIL small_by_big got %0d r %0d want 0 r 5",
                  bus.quotient, bus.remainder);
      else passed++;
      step();
      launch(16'hFFFF, 16'hFFFF);
      wait_done(bcnt, tmo);
      total++;
      if (tmo || {bus.quotient, bus.remainder} !== {16'd1, 16'd0})
         $display("FAIL max_by_max got %0d r %0d want 1 r 0",
                  bus.quotient, bus.remainder);
      else passed++;
      step();
   endtask

   task automatic test_back_to_back();
      int bcnt;
      bit tmo;
      bus.start    = 1'b1;
      bus.dividend = 16'd100;
      bus.divisor  = 16'd7;
      step();
      bus.dividend = 16'd50;
      bus.divisor  = 16'd5;
      wait_done(bcnt, tmo);
      total++;
      if (tmo || {bus.quotient, bus.remainder} !== {16'd14, 16'd2})
         $display("FAIL held_first got %0d r %0d want 14 r 2",
                  bus.quotient, bus.remainder);
      else passed++;
      step();
      step();
      bus.start = 1'b0;
      total++;
      if (bus.busy !== 1'b1)
         $display("FAIL held_accept got busy %b want 1", bus.busy);
      else passed++;
      wait_done(bcnt, tmo);
      total++;
      if (tmo || {bus.quotient, bus.remainder} !== {16'd10, 16'd0})
         $display("FAIL held_second got %0d r %0d want 10 r 0",
                  bus.quotient, bus.remainder);
      else passed++;
      step();
      launch(16'd200, 16'd13);
      wait_done(bcnt, tmo);
      total++;
      if (tmo || {bus.quotient, bus.remainder} !== {16'd15, 16'd5})
         $display("FAIL b2b_200_13 got %0d r %0d want 15 r 5",
                  bus.quotient, bus.remainder);
      else passed++;
      step();
   endtask

   task automatic test_clr_abort();
      int bcnt;
      bit tmo;
      bit seen;
      launch(16'd100, 16'd7);
      for (int i = 0; i < 7; i++) step();
      clr = 1'b1;
      #1;
      total++;
      if ({bus.busy, bus.done, bus.div_by_zero,
           bus.quotient, bus.remainder} !== 35'h0)
         $display("FAIL clr_outputs got b%b d%b z%b q%h r%h want all 0",
                  bus.busy, bus.done, bus.div_by_zero,
                  bus.quotient, bus.remainder);
      else passed++;
      @(negedge clk);
      clr = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.done || bus.busy) seen = 1'b1;
      end
      total++;
      if (seen)
         $display("FAIL clr_no_done got activity 1 want 0");
      else passed++;
      launch(16'd100, 16'd7);
      wait_done(bcnt, tmo);
      total++;
      if (tmo || bcnt != 16 ||
          {bus.quotient, bus.remainder} !== {16'd14, 16'd2})
         $display("FAIL clr_restart got %0d r %0d n %0d want 14 r 2 n 16",
                  bus.quotient, bus.remainder, bcnt);
      else passed++;
      step();
   endtask

   initial begin
      total  = 0;
      passed = 0;
      test_reset();
      test_basic();
      test_div_zero();
      test_boundary();
      test_back_to_back();
      test_clr_abort();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 The block SHALL have parameter NBIT, default 16, giving the operand width in bits (legal range 2..32).
REQ-002 Port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port clr  input  1  reset; asynchronous, active-high.
REQ-004 Port start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 Port dividend  input  NBIT  unsigned dividend; captured on the accepting edge.
REQ-006 Port divisor  input  NBIT  unsigned divisor; captured on the accepting edge.
REQ-007 Port busy  output  1  high while an iteration is in progress (state RUN).
REQ-008 Port done  output  1  single-cycle pulse; results valid.
REQ-009 Port quotient  output  NBIT  registered quotient, held until the next done.
REQ-010 Port remainder  output  NBIT  registered remainder, held until the next done.
REQ-011 Port div_by_zero  output  1  high with done when the captured divisor was 0; held with the results.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE with start=1 and divisor!=0: capture A=0, Q=dividend, M=divisor, load the iteration counter with NBIT-1, and go to RUN.
REQ-014 IDLE with start=1 and divisor=0: go directly to DONE; on that same edge, load quotient=all ones, remainder=dividend, div_by_zero=1.
REQ-015 RUN, each cycle (restoring, unsigned): shift {A,Q} left by 1; T = A_shifted - M computed at NBIT+1 bits; if T>=0 then A=T and Q[0]=1, else A is kept and Q[0]=0.
REQ-016 RUN: the counter decrements each cycle; an iteration with counter=0 is the last one and transitions to DONE.
REQ-017 On entering DONE from RUN, load quotient=Q_final, remainder=A_final and div_by_zero=0.
REQ-018 DONE: done=1 for exactly one cycle, then return unconditionally to IDLE.
REQ-019 Latency: with a nonzero divisor, done is high in the cycle following the NBIT-th rising edge after the start-sampling edge; with a zero divisor, it is high in the cycle following the start-sampling edge.
REQ-020 busy SHALL be 1 iff state=RUN; done SHALL be 1 iff state=DONE; both are decoded from registered state.
REQ-021 start in RUN or DONE SHALL be ignored, with no queuing; dividend and divisor changes during RUN have no effect.
REQ-022 quotient, remainder and div_by_zero change only on the edge entering DONE and are otherwise held.
REQ-023 An operand of all ones with divisor 1 SHALL produce quotient all ones and remainder 0 without overflow (guaranteed by the NBIT+1-bit trial subtraction).

Reset
REQ-024 When clr=1, asynchronously set: state=IDLE, counter=0, A=0, Q=0, M=0, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
REQ-025 clr asserted mid-RUN SHALL abort the operation; no done pulse follows, and the next start after clr deasserts begins a fresh division.

Structure
REQ-026 A shared package div_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default NBIT constant.
REQ-027 One sub-module, div_shift_pair, SHALL implement the 2*NBIT {A,Q} register: async clr, load, shift-left with serial-in, and conditional A write; the FSM and counter stay in div_sequencer.
REQ-028 The counter width SHALL be $clog2(NBIT).

Verification
REQ-029 NBIT=16, dividend=100, divisor=7, start for 1 cycle -> busy for 16 cycles, then done=1 for one cycle; quotient=14, remainder=2, div_by_zero=0.
REQ-030 dividend=16'h1234, divisor=0 -> done in the cycle after the start edge, busy never high; quotient=16'hFFFF, remainder=16'h1234, div_by_zero=1.
REQ-031 dividend=16'hFFFF, divisor=1 -> quotient=16'hFFFF, remainder=0; separately, 5/9 -> quotient=0, remainder=5.
REQ-032 start held high through RUN with new operands 50/5 after accepting 100/7 -> result is 14 r 2; the 50/5 request is accepted only if start is still high in IDLE.
REQ-033 clr pulsed at RUN iteration 8 of 100/7 -> all outputs 0 immediately, no done; after clr deasserts, 100/7 started again -> 14 r 2.
